// File: rtl/crop_window.sv
// rtl/crop_window.sv - AXI4-Stream video crop: forwards pixels inside a programmable rectangle
// Window geometry is latched on each SOF beat; TUSER/TLAST are regenerated for the cropped frame.
module crop_window #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_DIM_WIDTH          = 12
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESET,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  input  logic                            S_AXIS_TLAST,
  input  logic                            S_AXIS_TUSER,
  input  logic [C_DIM_WIDTH-1:0]          crop_x,
  input  logic [C_DIM_WIDTH-1:0]          crop_y,
  input  logic [C_DIM_WIDTH-1:0]          crop_w,
  input  logic [C_DIM_WIDTH-1:0]          crop_h,
  output logic                            wr_en,
  input  logic                            full,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] data_out,
  output logic                            last_out,
  output logic                            user_out,
  output logic                            frame_done,
  output logic                            sof_err,
  output logic                            line_err
);

  localparam int DW = C_DIM_WIDTH;

  typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                          state_q, state_d;
  logic [DW-1:0]                   x_q, x_d, y_q, y_d;
  logic [DW-1:0]                   cx_q, cx_d, cy_q, cy_d, cw_q, cw_d, ch_q, ch_d;
  logic                            wr_en_q, wr_en_d;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] data_q, data_d;
  logic                            last_q, last_d, user_q, user_d;
  logic                            done_q, done_d;
  logic                            sof_err_q, sof_err_d, line_err_q, line_err_d;

  logic          acc, sof, take, in_win, last_col, last_row, win_done;
  logic [DW-1:0] px, py;
  logic [DW:0]   x_end, y_end;

  assign S_AXIS_TREADY = !S_AXIS_ARESET && !full;
  assign acc           = S_AXIS_TVALID && S_AXIS_TREADY;

  always_comb begin
    sof  = acc && S_AXIS_TUSER;
    take = acc && (S_AXIS_TUSER || (state_q == ACTIVE));

    // An SOF beat uses the freshly sampled geometry and sits at (0,0).
    cx_d = sof ? crop_x : cx_q;
    cy_d = sof ? crop_y : cy_q;
    cw_d = sof ? crop_w : cw_q;
    ch_d = sof ? crop_h : ch_q;
    px   = sof ? '0 : x_q;
    py   = sof ? '0 : y_q;

    // One extra bit keeps the right/bottom edge sums from wrapping.
    x_end    = {1'b0, cx_d} + {1'b0, cw_d};
    y_end    = {1'b0, cy_d} + {1'b0, ch_d};
    in_win   = ({1'b0, px} >= {1'b0, cx_d}) && ({1'b0, px} < x_end) &&
               ({1'b0, py} >= {1'b0, cy_d}) && ({1'b0, py} < y_end);
    last_col = (({1'b0, px} + (DW+1)'(1)) == x_end);
    last_row = (({1'b0, py} + (DW+1)'(1)) == y_end);
    win_done = in_win && last_col && last_row;

    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    wr_en_d    = 1'b0;
    data_d     = data_q;
    last_d     = last_q;
    user_d     = user_q;
    done_d     = 1'b0;
    sof_err_d  = sof_err_q;
    line_err_d = line_err_q;

    // A degenerate window never completes, so its following SOF is not an error.
    if (sof && (state_q == ACTIVE) && (cw_q != '0) && (ch_q != '0)) begin
      sof_err_d = 1'b1;
    end

    if (take) begin
      if (S_AXIS_TLAST) begin
        x_d = '0;
        y_d = (py == '1) ? py : py + DW'(1);
      end else begin
        x_d = (px == '1) ? px : px + DW'(1);
        y_d = py;
      end
      state_d = win_done ? WAIT_SOF : ACTIVE;
      if (in_win) begin
        wr_en_d = 1'b1;
        data_d  = S_AXIS_TDATA;
        last_d  = last_col || S_AXIS_TLAST;
        user_d  = (px == cx_d) && (py == cy_d);
        done_d  = win_done;
        if (S_AXIS_TLAST && !last_col) begin
          line_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state_q    <= WAIT_SOF;
      x_q        <= '0;
      y_q        <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      cw_q       <= '0;
      ch_q       <= '0;
      wr_en_q    <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      user_q     <= 1'b0;
      done_q     <= 1'b0;
      sof_err_q  <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      cw_q       <= cw_d;
      ch_q       <= ch_d;
      wr_en_q    <= wr_en_d;
      data_q     <= data_d;
      last_q     <= last_d;
      user_q     <= user_d;
      done_q     <= done_d;
      sof_err_q  <= sof_err_d;
      line_err_q <= line_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign data_out   = data_q;
  assign last_out   = last_q;
  assign user_out   = user_q;
  assign frame_done = done_q;
  assign sof_err    = sof_err_q;
  assign line_err   = line_err_q;

endmodule

// File: tb/tb_crop_window.sv
// tb/tb_crop_window.sv - self-checking bench for crop_window
// Vector table of whole-frame crops, hand-written corner sequences, then randomized frames vs a model.
module tb_crop_window;

  typedef struct {
    logic [31:0] data;
    logic        user;
    logic        last;
    logic [11:0] cx, cy, cw, ch;
  } beat_t;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        last;
    logic        user;
    logic        done;
  } wr_t;

  typedef struct {
    int w, h, cx, cy, cw, ch, pf, n, first, last, done;
  } vec_t;

  logic        clk, rst;
  logic [31:0] tdata;
  logic        tvalid, tready, tlast, tuser;
  logic [11:0] cx, cy, cw, ch;
  logic        wr_en, full;
  logic [31:0] data_out;
  logic        last_out, user_out, frame_done, sof_err, line_err;

  int checks, failures;

  beat_t beats[$];
  wr_t   got[$];
  wr_t   exp_q[$];
  vec_t  vecs[9];

  bit m_wait, m_sof_err, m_line_err;
  int m_x, m_y, m_cx, m_cy, m_cw, m_ch;

  crop_window #(.C_S_AXIS_TDATA_WIDTH(32), .C_DIM_WIDTH(12)) dut (
    .S_AXIS_ACLK(clk),
    .S_AXIS_ARESET(rst),
    .S_AXIS_TDATA(tdata),
    .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready),
    .S_AXIS_TLAST(tlast),
    .S_AXIS_TUSER(tuser),
    .crop_x(cx),
    .crop_y(cy),
    .crop_w(cw),
    .crop_h(ch),
    .wr_en(wr_en),
    .full(full),
    .data_out(data_out),
    .last_out(last_out),
    .user_out(user_out),
    .frame_done(frame_done),
    .sof_err(sof_err),
    .line_err(line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en || frame_done) got.push_back('{wr_en, data_out, last_out, user_out, frame_done});
    checks++;
    if (tready !== (!rst && !full)) begin
      failures++;
      $display("FAIL tready: got %0b expected %0b", tready, (!rst && !full));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic clear_all();
    got.delete();
    exp_q.delete();
    beats.delete();
  endtask

  task automatic model_reset();
    m_wait = 1; m_sof_err = 0; m_line_err = 0;
    m_x = 0; m_y = 0; m_cx = 0; m_cy = 0; m_cw = 0; m_ch = 0;
  endtask

  // Walks the queued beats with the crop rules in plain integer arithmetic.
  task automatic model_run();
    int  x_last, y_last;
    bit  in_w, done;
    for (int i = 0; i < beats.size(); i++) begin
      if (beats[i].user) begin
        if (!m_wait && m_cw != 0 && m_ch != 0) m_sof_err = 1;
        m_cx = beats[i].cx; m_cy = beats[i].cy; m_cw = beats[i].cw; m_ch = beats[i].ch;
        m_x = 0; m_y = 0; m_wait = 0;
      end
      if (!m_wait) begin
        x_last = m_cx + m_cw - 1;
        y_last = m_cy + m_ch - 1;
        in_w = (m_x >= m_cx) && (m_x <= x_last) && (m_y >= m_cy) && (m_y <= y_last);
        done = in_w && (m_x == x_last) && (m_y == y_last);
        if (in_w) begin
          exp_q.push_back('{1'b1, beats[i].data, (m_x == x_last) || beats[i].last,
                            (m_x == m_cx) && (m_y == m_cy), done});
          if (beats[i].last && m_x != x_last) m_line_err = 1;
        end
        if (beats[i].last) begin
          m_x = 0;
          m_y = (m_y == 4095) ? 4095 : m_y + 1;
        end else begin
          m_x = (m_x == 4095) ? 4095 : m_x + 1;
        end
        if (done) m_wait = 1;
      end
    end
  endtask

  // Pixel value = tag<<24 | y*16+x; non-SOF beats carry junk geometry that must be ignored.
  task automatic add_frame(input int tag, input int w, input int h, input int fx, input int fy,
                           input int fw, input int fh, input int short_row, input int short_len);
    int    len;
    beat_t b;
    for (int y = 0; y < h; y++) begin
      len = (y == short_row) ? short_len : w;
      for (int x = 0; x < len; x++) begin
        b.data = (tag << 24) | (y * 16 + x);
        b.user = (x == 0 && y == 0);
        b.last = (x == len - 1);
        if (b.user) begin
          b.cx = 12'(fx); b.cy = 12'(fy); b.cw = 12'(fw); b.ch = 12'(fh);
        end else begin
          b.cx = 12'($urandom); b.cy = 12'($urandom); b.cw = 12'($urandom); b.ch = 12'($urandom);
        end
        beats.push_back(b);
      end
    end
  endtask

  task automatic drive(input int pct_full, input int pct_idle, input int tail);
    int i, guard;
    i = 0; guard = 0;
    while (i < beats.size() && guard < 20000) begin
      @(negedge clk);
      guard++;
      full   = ($urandom_range(0, 99) < pct_full);
      tvalid = ($urandom_range(0, 99) >= pct_idle);
      tdata  = beats[i].data;
      tuser  = beats[i].user;
      tlast  = beats[i].last;
      cx = beats[i].cx; cy = beats[i].cy; cw = beats[i].cw; ch = beats[i].ch;
      @(posedge clk);
      if (tvalid && !full) i++;
    end
    chk("drive.accepted", i, beats.size());
    if (tail > 0) begin
      @(negedge clk);
      tvalid = 0; full = 0; tuser = 0; tlast = 0;
      repeat (tail) @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; tvalid = 0; full = 0; tuser = 0; tlast = 0;
    @(posedge clk);
    #1;
    chk("reset.flags", {wr_en, last_out, user_out, frame_done, sof_err, line_err, tready}, 0);
    chk("reset.data", data_out, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic check_stream(input string name);
    chk($sformatf("%s.count", name), got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s.w%0d", name, i),
          {got[i].wr, got[i].last, got[i].user, got[i].done, got[i].data},
          {exp_q[i].wr, exp_q[i].last, exp_q[i].user, exp_q[i].done, exp_q[i].data});
    end
    chk($sformatf("%s.flags", name), {sof_err, line_err}, {m_sof_err, m_line_err});
  endtask

  function automatic int n_done();
    int n = 0;
    foreach (got[i]) if (got[i].done) n++;
    return n;
  endfunction

  initial begin
    int w, h, n0, nfr;
    checks = 0; failures = 0;
    rst = 1; tvalid = 0; full = 0; tuser = 0; tlast = 0; tdata = 0;
    cx = 0; cy = 0; cw = 0; ch = 0;
    model_reset();

    //           w    h   cx   cy  cw  ch  pf  n  first    last    done
    vecs[0] = '{8,    4,  2,   1,  3,  2,  0,  6, 'h12,    'h24,   1};
    vecs[1] = '{8,    4,  2,   1,  3,  2,  50, 6, 'h12,    'h24,   1};
    vecs[2] = '{8,    4,  0,   0,  8,  4,  0,  32, 'h00,   'h37,   1};
    vecs[3] = '{8,    4,  7,   3,  1,  1,  30, 1, 'h37,    'h37,   1};
    vecs[4] = '{8,    4,  0,   0,  1,  1,  0,  1, 'h00,    'h00,   1};
    vecs[5] = '{8,    4,  6,   2,  5,  5,  20, 4, 'h26,    'h37,   0};
    vecs[6] = '{8,    4,  3,   1,  0,  2,  0,  0, 0,       0,      0};
    vecs[7] = '{1,    3,  0,   0,  1,  3,  0,  3, 'h00,    'h20,   1};
    vecs[8] = '{4100, 1,  4095, 0, 1,  2,  0,  5, 'hfff,   'h1003, 0};

    repeat (2) @(posedge clk);

    for (int k = 0; k < 9; k++) begin
      do_reset();
      clear_all();
      add_frame(k + 16, vecs[k].w, vecs[k].h, vecs[k].cx, vecs[k].cy, vecs[k].cw, vecs[k].ch, -1, 0);
      model_run();
      drive(vecs[k].pf, 0, 3);
      check_stream($sformatf("vec%0d", k));
      chk($sformatf("vec%0d.n", k), got.size(), vecs[k].n);
      if (got.size() > 0 && vecs[k].n > 0) begin
        chk($sformatf("vec%0d.first", k), got[0].data[23:0], vecs[k].first);
        chk($sformatf("vec%0d.last", k), got[got.size()-1].data[23:0], vecs[k].last);
      end
      chk($sformatf("vec%0d.done", k), n_done(), vecs[k].done);
    end

    // Mid-frame SOF: frame 1 interrupted at column 5 of row 2, then a full frame.
    do_reset();
    clear_all();
    add_frame(1, 8, 4, 2, 2, 3, 2, -1, 0);
    while (beats.size() > 21) void'(beats.pop_back());
    add_frame(2, 8, 4, 2, 1, 3, 2, -1, 0);
    model_run();
    drive(30, 10, 3);
    check_stream("midsof");
    chk("midsof.sof_err", sof_err, 1);
    chk("midsof.n", got.size(), 9);
    if (got.size() == 9) begin
      chk("midsof.first_new", got[3].data, 32'h0200_0012);
      chk("midsof.last_new", got[8].data, 32'h0200_0024);
    end

    // Short line: row 1 ends at x=3 inside the window.
    do_reset();
    clear_all();
    add_frame(3, 8, 4, 2, 1, 3, 2, 1, 4);
    model_run();
    drive(0, 0, 3);
    check_stream("short");
    chk("short.n", got.size(), 5);
    if (got.size() > 1) chk("short.last13", {got[1].data[7:0], got[1].last}, {8'h13, 1'b1});
    chk("short.line_err", line_err, 1);

    // Reset right after the second window write.
    do_reset();
    clear_all();
    add_frame(6, 8, 4, 2, 1, 3, 2, -1, 0);
    while (beats.size() > 12) void'(beats.pop_back());
    model_run();
    drive(0, 0, 0);
    do_reset();
    check_stream("rst.pre");
    chk("rst.pre.n", got.size(), 2);
    clear_all();
    add_frame(6, 8, 4, 2, 1, 3, 2, -1, 0);
    repeat (12) void'(beats.pop_front());
    model_run();
    drive(20, 0, 3);
    chk("rst.orphan.n", got.size(), 0);
    clear_all();
    add_frame(7, 8, 4, 2, 1, 3, 2, -1, 0);
    model_run();
    drive(20, 0, 3);
    check_stream("rst.post");
    chk("rst.post.n", got.size(), 6);

    // Degenerate window followed by a full-frame crop.
    do_reset();
    clear_all();
    add_frame(4, 8, 4, 1, 1, 0, 2, -1, 0);
    add_frame(5, 8, 4, 0, 0, 8, 4, -1, 0);
    model_run();
    drive(25, 10, 3);
    check_stream("degen");
    chk("degen.n", got.size(), 32);
    chk("degen.sof_err", sof_err, 0);
    chk("degen.done", n_done(), 1);
    if (got.size() > 0) chk("degen.user0", {got[0].user, got[0].data}, {1'b1, 32'h0500_0000});

    // Randomized frames, some interrupted by the next SOF.
    for (int it = 0; it < 10; it++) begin
      do_reset();
      clear_all();
      nfr = $urandom_range(2, 3);
      for (int f = 0; f < nfr; f++) begin
        w = $urandom_range(1, 10);
        h = $urandom_range(1, 5);
        n0 = beats.size();
        add_frame(it * 4 + f + 64, w, h, $urandom_range(0, w), $urandom_range(0, h),
                  $urandom_range(0, w), $urandom_range(0, h), $urandom_range(0, 6), $urandom_range(1, w));
        if ($urandom_range(0, 2) == 0) begin
          n0 = n0 + $urandom_range(1, beats.size() - n0);
          while (beats.size() > n0) void'(beats.pop_back());
        end
      end
      model_run();
      drive($urandom_range(0, 60), $urandom_range(0, 30), 3);
      check_stream($sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
